// File: rtl/riscv_wbu_ctrl_pkg.sv
// Shared definitions for the writeback controller: LSU opcode values,
// interface defaults and the controller state encoding.
package riscv_wbu_ctrl_pkg;

   localparam int unsigned DATA_WIDTH_DEF    = 32;
   localparam int unsigned LSU_OPT_WIDTH_DEF = 4;

   localparam logic [3:0] LSU_OPT_NONE = 4'd0;
   localparam logic [3:0] LSU_OPT_SYS  = 4'd1;

   typedef enum logic [1:0] {
      WBC_IDLE = 2'd0,
      WBC_WAIT = 2'd1,
      WBC_WB   = 2'd2
   } wbc_state_e;

endpackage

// File: rtl/riscv_wbu_wdt.sv
// LSU wait counter: cleared when a memory access is accepted, counts
// cycles spent waiting and flags the last allowed wait cycle.
module riscv_wbu_wdt #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins over increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/riscv_wbu_ctrl.sv
// Writeback controller: accepts one retiring instruction, waits for the
// LSU on memory ops, then drives the register-file write and commit strobe.
module riscv_wbu_ctrl
   import riscv_wbu_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned LSU_OPT_WIDTH  = LSU_OPT_WIDTH_DEF,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_pc,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic                      in_rd_wen,
   input  logic [LSU_OPT_WIDTH-1:0]  in_lsu_opt,
   input  logic [DATA_WIDTH-1:0]     in_exu_result,
   input  logic [DATA_WIDTH-1:0]     in_csr_result,
   input  logic                      lsu_done,
   input  logic [DATA_WIDTH-1:0]     lsu_rdata,
   output logic                      rf_wen,
   output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]     rf_wdata,
   output logic                      commit_valid,
   output logic [DATA_WIDTH-1:0]     commit_pc,
   output logic                      commit_err,
   output logic                      pend_valid,
   output logic [REG_ADDR_WIDTH-1:0] pend_rd
);

   wbc_state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0]     pc_q, pc_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                      rd_wen_q, rd_wen_d;
   logic [DATA_WIDTH-1:0]     res_q, res_d;
   logic                      err_q, err_d;

   logic                      rf_wen_q, rf_wen_d;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
   logic                      commit_valid_q, commit_valid_d;
   logic [DATA_WIDTH-1:0]     commit_pc_q, commit_pc_d;
   logic                      commit_err_q, commit_err_d;
   logic                      pend_valid_q, pend_valid_d;

   logic accept;
   logic wdt_clr;
   logic wdt_en;
   logic wdt_expired;
   logic going_wb;

   assign in_ready = rst_n && (state_q == WBC_IDLE || state_q == WBC_WB);
   assign accept   = in_valid && in_ready;

   riscv_wbu_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wdt_clr),
      .en      (wdt_en),
      .expired (wdt_expired)
   );

   // Next-state, latched-instruction and registered-output computation.
   // The EXU/CSR choice is resolved at accept time into one result register,
   // which a load later overwrites with lsu_rdata.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rd_d     = rd_q;
      rd_wen_d = rd_wen_q;
      res_d    = res_q;
      err_d    = err_q;
      wdt_clr  = 1'b0;
      wdt_en   = 1'b0;

      case (state_q)
         WBC_WAIT: begin
            if (lsu_done) begin
               res_d   = lsu_rdata;
               state_d = WBC_WB;
            end else if (wdt_expired) begin
               err_d   = 1'b1;
               state_d = WBC_WB;
            end else begin
               wdt_en  = 1'b1;
            end
         end
         default: begin
            if (accept) begin
               pc_d     = in_pc;
               rd_d     = in_rd;
               rd_wen_d = in_rd_wen;
               err_d    = 1'b0;
               if (in_lsu_opt == LSU_OPT_WIDTH'(LSU_OPT_NONE)) begin
                  res_d   = in_exu_result;
                  state_d = WBC_WB;
               end else if (in_lsu_opt == LSU_OPT_WIDTH'(LSU_OPT_SYS)) begin
                  res_d   = in_csr_result;
                  state_d = WBC_WB;
               end else begin
                  wdt_clr = 1'b1;
                  state_d = WBC_WAIT;
               end
            end else begin
               state_d = WBC_IDLE;
            end
         end
      endcase

      going_wb       = (state_d == WBC_WB);
      rf_wen_d       = going_wb && rd_wen_d && (rd_d != '0) && !err_d;
      rf_waddr_d     = going_wb ? rd_d  : rf_waddr_q;
      rf_wdata_d     = going_wb ? res_d : rf_wdata_q;
      commit_valid_d = going_wb;
      commit_pc_d    = going_wb ? pc_d  : commit_pc_q;
      commit_err_d   = going_wb && err_d;
      pend_valid_d   = (state_d != WBC_IDLE) && rd_wen_d && (rd_d != '0);
   end

   // State, latched instruction and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= WBC_IDLE;
         pc_q           <= '0;
         rd_q           <= '0;
         rd_wen_q       <= 1'b0;
         res_q          <= '0;
         err_q          <= 1'b0;
         rf_wen_q       <= 1'b0;
         rf_waddr_q     <= '0;
         rf_wdata_q     <= '0;
         commit_valid_q <= 1'b0;
         commit_pc_q    <= '0;
         commit_err_q   <= 1'b0;
         pend_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         rd_q           <= rd_d;
         rd_wen_q       <= rd_wen_d;
         res_q          <= res_d;
         err_q          <= err_d;
         rf_wen_q       <= rf_wen_d;
         rf_waddr_q     <= rf_waddr_d;
         rf_wdata_q     <= rf_wdata_d;
         commit_valid_q <= commit_valid_d;
         commit_pc_q    <= commit_pc_d;
         commit_err_q   <= commit_err_d;
         pend_valid_q   <= pend_valid_d;
      end
   end

   assign rf_wen       = rf_wen_q;
   assign rf_waddr     = rf_waddr_q;
   assign rf_wdata     = rf_wdata_q;
   assign commit_valid = commit_valid_q;
   assign commit_pc    = commit_pc_q;
   assign commit_err   = commit_err_q;
   assign pend_valid   = pend_valid_q;
   assign pend_rd      = rd_q;

endmodule
